// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage.
// Produces the sequential fetch address and applies exception, jump and
// branch redirects in priority order. Redirects that arrive while the
// front end is stalled are buffered and applied once the stall clears.
// A small run-control FSM (IDLE/RUN/HALT) decides when pc_o is a valid fetch.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0080),
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            hold_i,
    input  logic            halt_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_tgt_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_tgt_i,
    input  logic            exc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            pend_o,
    output logic            misalign_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Number of low address bits that must be zero for an instruction fetch.
    localparam int              ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] INCR       = XLEN'(INSTR_BYTES);

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic            pend_reg;
    logic [XLEN-1:0] pend_tgt_reg;
    logic            misalign_reg;

    // Per-bit keep mask: bits below ALIGN_BITS are forced to zero in targets.
    logic [XLEN-1:0] align_keep;
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_align
        assign align_keep[gi] = (gi >= ALIGN_BITS);
    end

    logic            stalled;
    logic            buf_valid;
    logic [XLEN-1:0] buf_tgt;
    logic            app_valid;
    logic [XLEN-1:0] app_raw;
    logic [XLEN-1:0] app_aligned;
    logic            app_mis;

    // Redirect selection: what would be buffered if stalled, and what would be
    // applied if not. A buffered redirect outranks same-cycle branch/jump,
    // which come from an instruction that is being squashed.
    always_comb begin
        stalled   = stall_i | hold_i;
        buf_valid = jump_i | branch_i;
        buf_tgt   = jump_i ? jump_tgt_i : branch_tgt_i;
        app_valid = 1'b0;
        app_raw   = '0;
        if (pend_reg) begin
            app_valid = 1'b1;
            app_raw   = pend_tgt_reg;
        end else if (jump_i) begin
            app_valid = 1'b1;
            app_raw   = jump_tgt_i;
        end else if (branch_i) begin
            app_valid = 1'b1;
            app_raw   = branch_tgt_i;
        end
        app_aligned = app_raw & align_keep;
        app_mis     = |(app_raw & ~align_keep);
    end

    // Run-control FSM together with PC, pending buffer and misalign pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_VECTOR;
            pend_reg     <= 1'b0;
            pend_tgt_reg <= '0;
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= 1'b0;
            if (!start_i) begin
                state_reg <= ST_IDLE;
                pc_reg    <= RESET_VECTOR;
                pend_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // First RUN cycle fetches at the reset vector.
                        state_reg <= ST_RUN;
                        pc_reg    <= RESET_VECTOR;
                        pend_reg  <= 1'b0;
                    end
                    ST_RUN: begin
                        if (exc_i) begin
                            // Exception flushes the pipe, stalled or not.
                            pc_reg   <= EXC_VECTOR;
                            pend_reg <= 1'b0;
                        end else if (stalled) begin
                            // Hold the PC; newest redirect replaces any older one.
                            if (buf_valid) begin
                                pend_reg     <= 1'b1;
                                pend_tgt_reg <= buf_tgt;
                            end
                        end else begin
                            if (app_valid) begin
                                pc_reg       <= app_aligned;
                                misalign_reg <= app_mis;
                                pend_reg     <= 1'b0;
                            end else if (!halt_i) begin
                                pc_reg <= pc_reg + INCR;
                            end
                            // A same-cycle redirect lands first, then we halt on it.
                            if (halt_i) begin
                                state_reg <= ST_HALT;
                            end
                        end
                    end
                    ST_HALT: begin
                        if (exc_i) begin
                            state_reg <= ST_RUN;
                            pc_reg    <= EXC_VECTOR;
                            pend_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        pc_reg    <= RESET_VECTOR;
                        pend_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pc_o       = pc_reg;
    assign pc_valid_o = (state_reg == ST_RUN) && !stalled;
    assign pend_o     = pend_reg;
    assign misalign_o = misalign_reg;
    assign state_o    = state_reg;

endmodule
